spi_ram_arbiter: RTL
====================

SPI_RAM_ARBITER -- requirements
Module: spi_ram_arbiter

Interface
REQ-001 SHALL have parameter: ADDR_SIZE, 8, RAM address width and width of every address/data field.
REQ-002 SHALL have parameter: MEM_DEPTH, 256, RAM depth; addresses wrap modulo MEM_DEPTH.
REQ-003 SHALL have port: clk  in  1  sole clock; all logic on posedge clk.
REQ-004 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port: rx_data  in  ADDR_SIZE+2  SPI slave word; [9:8] command, [7:0] payload.
REQ-006 SHALL have port: rx_valid  in  1  one-cycle strobe qualifying rx_data.
REQ-007 SHALL have port: tx_data  out  ADDR_SIZE  SPI read return data.
REQ-008 SHALL have port: tx_valid  out  1  one-cycle strobe qualifying tx_data.
REQ-009 SHALL have port: host_req  in  1  host access request, held until host_gnt.
REQ-010 SHALL have port: host_we  in  1  host write (1) / read (0).
REQ-011 SHALL have port: host_addr  in  ADDR_SIZE  host address.
REQ-012 SHALL have port: host_wdata  in  ADDR_SIZE  host write data.
REQ-013 SHALL have port: host_gnt  out  1  one-cycle grant; host request consumed.
REQ-014 SHALL have port: host_rdata  out  ADDR_SIZE  host read data.
REQ-015 SHALL have port: host_rvalid  out  1  one-cycle strobe qualifying host_rdata.
REQ-016 SHALL have port: ram_en, ram_we  out  1 each  single-port RAM enable / write enable.
REQ-017 SHALL have port: ram_addr, ram_wdata  out  ADDR_SIZE each  RAM address / write data.
REQ-018 SHALL have port: ram_rdata  in  ADDR_SIZE  RAM read data, valid the cycle after ram_en with ram_we=0.
REQ-019 SHALL have port: busy  out  1  high whenever the FSM is not IDLE.
REQ-020 SHALL have port: ovf  out  1  sticky SPI command overflow flag.

Function
REQ-021 SHALL decode on rx_valid: 00 latch wr_addr, 01 write data, 10 latch rd_addr, 11 read data (payload ignored).
REQ-022 SHALL update wr_addr/rd_addr the cycle after rx_valid without RAM access or arbitration.
REQ-023 SHALL hold commands 01/11 in a one-entry pending slot (spi_pend) until served.
REQ-024 SHALL drop a 01/11 command arriving while spi_pend is set and not being consumed that cycle, and set ovf (cleared only by rst).
REQ-025 SHALL accept a new 01/11 command in the same cycle the pending one is consumed (GNT_SPI), with no ovf.
REQ-026 SHALL implement FSM states IDLE, GNT_SPI, GNT_HOST, RD_WAIT.
REQ-027 SHALL in IDLE, if spi_pend or host_req, select a winner and move to GNT_SPI/GNT_HOST next cycle; else stay IDLE.
REQ-028 SHALL in GNT_x drive ram_en=1 for exactly one cycle with ram_we/addr/wdata of the winner; host_gnt=1 in GNT_HOST only.
REQ-029 SHALL return from GNT_x to IDLE for writes and go to RD_WAIT for reads; RD_WAIT returns to IDLE after one cycle.
REQ-030 SHALL register ram_rdata at end of RD_WAIT into tx_data (SPI) or host_rdata (host) and pulse tx_valid or host_rvalid for one cycle.
REQ-031 SHALL give latency: rx_valid cycle N -> ram_en at N+2; SPI read tx_valid at N+4; host_req in IDLE at M -> host_gnt M+1, host_rvalid M+3.
REQ-032 SHALL hold ram_en=0 and ram_we=0 outside GNT states; ram_addr/ram_wdata hold last value.

Reset
REQ-033 SHALL on rst force IDLE, clear spi_pend, wr_addr, rd_addr, ovf, and arbitration history.
REQ-034 SHALL reset every output to 0: tx_data, tx_valid, host_gnt, host_rdata, host_rvalid, ram_en, ram_we, ram_addr, ram_wdata, busy, ovf.
REQ-035 SHALL discard an in-flight read when rst asserts in GNT or RD_WAIT; no valid strobe is produced.

Configuration
REQ-036 SHALL, with RR_ARB_EN defined, on simultaneous spi_pend and host_req grant the requester not served last; after reset SPI wins the first tie.
REQ-037 SHALL, without RR_ARB_EN, always grant SPI on a tie (fixed priority).

Verification
REQ-038 SHALL cover: rx 0x022, then 0x1A5 -> ram_en=1, ram_we=1, ram_addr=0x22, ram_wdata=0xA5 two cycles after second rx_valid.
REQ-039 SHALL cover: rx 0x222, 0x300, ram_rdata=0xA5 -> tx_data=0xA5, tx_valid one cycle at N+4.
REQ-040 SHALL cover: host_req read addr 0x10 in IDLE, ram_rdata=0x5C -> host_gnt at +1, host_rvalid=1, host_rdata=0x5C at +3.
REQ-041 SHALL cover: spi_pend and host_req together twice -> RR_ARB_EN: SPI then host; without macro: SPI both times.
REQ-042 SHALL cover: two 01 commands while host holds RAM -> second dropped, ovf=1 until rst.
REQ-043 SHALL cover: rst during RD_WAIT -> next cycle all outputs 0, no tx_valid/host_rvalid pulse, state IDLE.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// spi_ram_arbiter: shares one single-port RAM between SPI slave commands and a host port; define RR_ARB_EN for round-robin ties
module spi_ram_arbiter #(
    parameter int ADDR_SIZE = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_SIZE+1:0] rx_data,
    input  logic                 rx_valid,
    output logic [ADDR_SIZE-1:0] tx_data,
    output logic                 tx_valid,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [ADDR_SIZE-1:0] host_addr,
    input  logic [ADDR_SIZE-1:0] host_wdata,
    output logic                 host_gnt,
    output logic [ADDR_SIZE-1:0] host_rdata,
    output logic                 host_rvalid,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_SIZE-1:0] ram_addr,
    output logic [ADDR_SIZE-1:0] ram_wdata,
    input  logic [ADDR_SIZE-1:0] ram_rdata,
    output logic                 busy,
    output logic                 ovf
);
    typedef enum logic [1:0] {IDLE, GNT_SPI, GNT_HOST, RD_WAIT} state_t;
    state_t r_state, w_next;
    logic [1:0] w_cmd;
    logic [ADDR_SIZE-1:0] w_payload, w_sel_addr, w_sel_wdata;
    logic w_spi_cmd, w_consume, w_go, w_host_win, w_sel_we;
    logic r_spi_pend, r_pend_rd, r_rd_host, r_ovf;
    logic [ADDR_SIZE-1:0] r_pend_data, r_wr_addr, r_rd_addr;
    logic r_ram_en, r_ram_we, r_tx_valid, r_host_rvalid;
    logic [ADDR_SIZE-1:0] r_ram_addr, r_ram_wdata, r_tx_data, r_host_rdata;
`ifdef RR_ARB_EN
    logic r_last_spi;
`endif
    always_comb begin
        w_cmd       = rx_data[ADDR_SIZE+1:ADDR_SIZE];
        w_payload   = rx_data[ADDR_SIZE-1:0];
        w_spi_cmd   = rx_valid && w_cmd[0];
        w_consume   = r_state == GNT_SPI;
        w_go        = r_state == IDLE && (r_spi_pend || host_req);
`ifdef RR_ARB_EN
        w_host_win  = host_req && (!r_spi_pend || r_last_spi);
`else
        w_host_win  = host_req && !r_spi_pend;
`endif
        w_sel_we    = w_host_win ? host_we : !r_pend_rd;
        w_sel_addr  = w_host_win ? host_addr : (r_pend_rd ? r_rd_addr : r_wr_addr);
        w_sel_wdata = w_host_win ? host_wdata : r_pend_data;
        w_next      = IDLE;
        case (r_state)
            IDLE:              w_next = !w_go ? IDLE : (w_host_win ? GNT_HOST : GNT_SPI);
            GNT_SPI, GNT_HOST: w_next = r_ram_we ? IDLE : RD_WAIT;
            default:           w_next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_spi_pend    <= 1'b0;
            r_pend_rd     <= 1'b0;
            r_pend_data   <= '0;
            r_wr_addr     <= '0;
            r_rd_addr     <= '0;
            r_ovf         <= 1'b0;
            r_rd_host     <= 1'b0;
            r_ram_en      <= 1'b0;
            r_ram_we      <= 1'b0;
            r_ram_addr    <= '0;
            r_ram_wdata   <= '0;
            r_tx_valid    <= 1'b0;
            r_tx_data     <= '0;
            r_host_rvalid <= 1'b0;
            r_host_rdata  <= '0;
`ifdef RR_ARB_EN
            r_last_spi    <= 1'b0;
`endif
        end else begin
            if (rx_valid && w_cmd == 2'b00) r_wr_addr <= w_payload;
            if (rx_valid && w_cmd == 2'b10) r_rd_addr <= w_payload;
            if (w_spi_cmd && r_spi_pend && !w_consume) r_ovf <= 1'b1;
            if (w_spi_cmd && (!r_spi_pend || w_consume)) begin
                r_spi_pend  <= 1'b1;
                r_pend_rd   <= w_cmd[1];
                r_pend_data <= w_payload;
            end else if (w_consume) begin
                r_spi_pend  <= 1'b0;
            end
            r_ram_en <= w_go;
            r_ram_we <= w_go && w_sel_we;
            if (w_go) begin
                r_ram_addr <= ADDR_SIZE'(w_sel_addr % MEM_DEPTH);
                r_rd_host  <= w_host_win;
            end
            if (w_go && w_sel_we) r_ram_wdata <= w_sel_wdata;
`ifdef RR_ARB_EN
            if (w_go) r_last_spi <= !w_host_win;
`endif
            r_tx_valid    <= r_state == RD_WAIT && !r_rd_host;
            r_host_rvalid <= r_state == RD_WAIT && r_rd_host;
            if (r_state == RD_WAIT && !r_rd_host) r_tx_data <= ram_rdata;
            if (r_state == RD_WAIT && r_rd_host) r_host_rdata <= ram_rdata;
        end
    end
    assign tx_data     = r_tx_data;
    assign tx_valid    = r_tx_valid;
    assign host_gnt    = r_state == GNT_HOST;
    assign host_rdata  = r_host_rdata;
    assign host_rvalid = r_host_rvalid;
    assign ram_en      = r_ram_en;
    assign ram_we      = r_ram_we;
    assign ram_addr    = r_ram_addr;
    assign ram_wdata   = r_ram_wdata;
    assign busy        = r_state != IDLE;
    assign ovf         = r_ovf;
endmodule
